// File: rtl/alu_seq_unit_pkg.sv
// Shared definitions for the accumulator ALU: opcodes, flag bit positions
// and FSM state encodings.
package alu_pkg;

   localparam logic [5:0] OP_ADD = 6'b001100;
   localparam logic [5:0] OP_SUB = 6'b001101;
   localparam logic [5:0] OP_AND = 6'b001110;
   localparam logic [5:0] OP_OR  = 6'b001111;
   localparam logic [5:0] OP_XOR = 6'b010000;
   localparam logic [5:0] OP_NOT = 6'b010001;
   localparam logic [5:0] OP_LSL = 6'b010010;
   localparam logic [5:0] OP_LSR = 6'b010011;
   localparam logic [5:0] OP_ROR = 6'b010100;
   localparam logic [5:0] OP_ROL = 6'b010101;
   localparam logic [5:0] OP_MUL = 6'b010110;
   localparam logic [5:0] OP_DIV = 6'b010111;
   localparam logic [5:0] OP_MOD = 6'b011000;
   localparam logic [5:0] OP_INC = 6'b011001;
   localparam logic [5:0] OP_DEC = 6'b011010;
   localparam logic [5:0] OP_CMP = 6'b011011;
   localparam logic [5:0] OP_TST = 6'b011100;
   localparam logic [5:0] OP_MOV = 6'b011101;

   localparam int FLG_Z = 3;
   localparam int FLG_N = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_EXEC   = 2'b01,
      ST_ITER   = 2'b10,
      ST_COMMIT = 2'b11
   } state_t;

   function automatic logic is_divmod(input logic [5:0] op);
      return (op == OP_DIV) || (op == OP_MOD);
   endfunction

   function automatic logic is_iter_op(input logic [5:0] op);
      return (op == OP_MUL) || is_divmod(op);
   endfunction

endpackage

// File: rtl/alu_seq_unit_if.sv
// Control-unit <-> ALU handshake and accumulator bus.
interface alu_seq_unit_if #(parameter int W = 16);

   logic         start;
   logic [5:0]   opcode;
   logic [W-1:0] operand;
   logic         acc_load;
   logic [W-1:0] acc_din;
   logic [W-1:0] acc;
   logic [3:0]   flags;
   logic         busy;
   logic         done;

   modport master (
      output start, opcode, operand, acc_load, acc_din,
      input  acc, flags, busy, done
   );

   modport slave (
      input  start, opcode, operand, acc_load, acc_din,
      output acc, flags, busy, done
   );

endinterface

// File: rtl/alu_seq_unit_muldiv.sv
// Iterative W-step engine: right-shift/add multiplier and restoring divider.
// hi/lo hold {product high, product low} or {remainder, quotient}.
module alu_muldiv_core #(
   parameter int W   = 16,
   parameter int SHW = $clog2(W)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         step,
   input  logic         is_div,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo,
   output logic         done
);

   logic         div_r;
   logic [W-1:0] b_r;
   logic [W-1:0] hi_r;
   logic [W-1:0] lo_r;
   logic [SHW-1:0] cnt_r;
   logic [W:0]   sum_s;
   logic [W:0]   trial_s;
   logic [W-1:0] addend_s;

   // per-step adder for multiply and trial subtractor for divide
   always_comb begin
      addend_s = {W{1'b0}};
      if (lo_r[0]) begin
         addend_s = b_r;
      end else begin
         addend_s = {W{1'b0}};
      end
      sum_s   = {1'b0, hi_r} + {1'b0, addend_s};
      trial_s = {hi_r, lo_r[W-1]} - {1'b0, b_r};
   end

   assign done = step && (cnt_r == {SHW{1'b1}});
   assign hi   = hi_r;
   assign lo   = lo_r;

   // operand load on start, one iteration per step
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_r <= 1'b0;
         b_r   <= {W{1'b0}};
         hi_r  <= {W{1'b0}};
         lo_r  <= {W{1'b0}};
         cnt_r <= {SHW{1'b0}};
      end else if (start) begin
         div_r <= is_div;
         b_r   <= b;
         hi_r  <= {W{1'b0}};
         lo_r  <= a;
         cnt_r <= {SHW{1'b0}};
      end else if (step) begin
         cnt_r <= cnt_r + {{(SHW-1){1'b0}}, 1'b1};
         if (div_r) begin
            // trial_s[W] set means the shifted remainder was smaller than the divisor
            if (!trial_s[W]) begin
               hi_r <= trial_s[W-1:0];
               lo_r <= {lo_r[W-2:0], 1'b1};
            end else begin
               hi_r <= {hi_r[W-2:0], lo_r[W-1]};
               lo_r <= {lo_r[W-2:0], 1'b0};
            end
         end else begin
            hi_r <= sum_s[W:1];
            lo_r <= {sum_s[0], lo_r[W-1:1]};
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/alu_seq_unit.sv
// Multi-cycle accumulator ALU: FSM, single-cycle datapath, accumulator and
// condition flags; multiply/divide delegated to alu_muldiv_core.
module alu_seq_unit
   import alu_pkg::*;
#(
   parameter int W   = 16,
   parameter int SHW = $clog2(W)
) (
   input  logic           clk,
   input  logic           rst,
   alu_seq_unit_if.slave  bus
);

   localparam logic [SHW-1:0] SH_ONE = {{(SHW-1){1'b0}}, 1'b1};

   state_t         state_r;
   logic [5:0]     op_r;
   logic [W-1:0]   b_r;
   logic [W-1:0]   acc_r;
   logic [3:0]     flags_r;
   logic           busy_r;
   logic           done_r;

   logic           iter_s;
   logic           div0_s;
   logic           core_start_s;
   logic           core_step_s;
   logic           core_done_s;
   logic [W-1:0]   core_hi_s;
   logic [W-1:0]   core_lo_s;

   logic [W-1:0]   ab_s;
   logic [W:0]     sum_s;
   logic [W:0]     dif_s;
   logic [SHW-1:0] sh_s;
   logic [SHW-1:0] neg_sh_s;
   logic [W-1:0]   res_s;
   logic           c_s;
   logic           v_s;
   logic           wr_acc_s;
   logic           known_s;
   logic [3:0]     flg_s;

   assign iter_s       = is_iter_op(bus.opcode);
   assign div0_s       = is_divmod(bus.opcode) && (bus.operand == {W{1'b0}});
   assign core_start_s = (state_r == ST_IDLE) && bus.start && iter_s && !div0_s;
   assign core_step_s  = (state_r == ST_ITER);

   alu_muldiv_core #(.W(W), .SHW(SHW)) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (core_start_s),
      .step   (core_step_s),
      .is_div (is_divmod(bus.opcode)),
      .a      (acc_r),
      .b      (bus.operand),
      .hi     (core_hi_s),
      .lo     (core_lo_s),
      .done   (core_done_s)
   );

   // result and flag computation for the latched opcode
   always_comb begin
      res_s    = acc_r;
      c_s      = 1'b0;
      v_s      = 1'b0;
      wr_acc_s = 1'b1;
      known_s  = 1'b1;
      flg_s    = 4'b0000;
      if ((op_r == OP_INC) || (op_r == OP_DEC)) begin
         ab_s = {{(W-1){1'b0}}, 1'b1};
      end else begin
         ab_s = b_r;
      end
      sum_s    = {1'b0, acc_r} + {1'b0, ab_s};
      dif_s    = {1'b0, acc_r} - {1'b0, ab_s};
      sh_s     = b_r[SHW-1:0];
      // (W - sh) mod W: index of the last bit shifted out by LSL, and the rotate complement
      neg_sh_s = ~sh_s + SH_ONE;
      case (op_r)
         OP_ADD, OP_INC: begin
            res_s = sum_s[W-1:0];
            c_s   = sum_s[W];
            v_s   = (acc_r[W-1] == ab_s[W-1]) && (sum_s[W-1] != acc_r[W-1]);
         end
         OP_SUB, OP_DEC, OP_CMP: begin
            res_s    = dif_s[W-1:0];
            c_s      = dif_s[W];
            v_s      = (acc_r[W-1] != ab_s[W-1]) && (dif_s[W-1] != acc_r[W-1]);
            wr_acc_s = (op_r != OP_CMP);
         end
         OP_AND: res_s = acc_r & b_r;
         OP_OR:  res_s = acc_r | b_r;
         OP_XOR: res_s = acc_r ^ b_r;
         OP_NOT: res_s = ~acc_r;
         OP_TST: begin
            res_s    = acc_r & b_r;
            wr_acc_s = 1'b0;
         end
         OP_LSL: begin
            res_s = acc_r << sh_s;
            if (sh_s != {SHW{1'b0}}) begin
               c_s = acc_r[neg_sh_s];
            end else begin
               c_s = 1'b0;
            end
         end
         OP_LSR: begin
            res_s = acc_r >> sh_s;
            if (sh_s != {SHW{1'b0}}) begin
               c_s = acc_r[sh_s - SH_ONE];
            end else begin
               c_s = 1'b0;
            end
         end
         OP_ROR: res_s = (acc_r >> sh_s) | (acc_r << neg_sh_s);
         OP_ROL: res_s = (acc_r << sh_s) | (acc_r >> neg_sh_s);
         OP_MUL: begin
            res_s = core_lo_s;
            c_s   = |core_hi_s;
         end
         OP_DIV, OP_MOD: begin
            if (b_r == {W{1'b0}}) begin
               res_s = {W{1'b1}};
               v_s   = 1'b1;
            end else if (op_r == OP_DIV) begin
               res_s = core_lo_s;
            end else begin
               res_s = core_hi_s;
            end
         end
         OP_MOV: res_s = b_r;
         default: begin
            known_s  = 1'b0;
            wr_acc_s = 1'b0;
         end
      endcase
      flg_s[FLG_Z] = (res_s == {W{1'b0}});
      flg_s[FLG_N] = res_s[W-1];
      flg_s[FLG_C] = c_s;
      flg_s[FLG_V] = v_s;
   end

   // sequencing FSM with registered acc, flags, busy and done
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         op_r    <= 6'b000000;
         b_r     <= {W{1'b0}};
         acc_r   <= {W{1'b0}};
         flags_r <= 4'b0000;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  op_r   <= bus.opcode;
                  b_r    <= bus.operand;
                  busy_r <= 1'b1;
                  if (div0_s) begin
                     state_r <= ST_COMMIT;
                  end else if (iter_s) begin
                     state_r <= ST_ITER;
                  end else begin
                     state_r <= ST_EXEC;
                  end
               end else if (bus.acc_load) begin
                  acc_r <= bus.acc_din;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_EXEC, ST_COMMIT: begin
               if (wr_acc_s) begin
                  acc_r <= res_s;
               end else begin
                  acc_r <= acc_r;
               end
               if (known_s) begin
                  flags_r <= flg_s;
               end else begin
                  flags_r <= flags_r;
               end
               done_r  <= 1'b1;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            ST_ITER: begin
               if (core_done_s) begin
                  state_r <= ST_COMMIT;
               end else begin
                  state_r <= ST_ITER;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   assign bus.acc   = acc_r;
   assign bus.flags = flags_r;
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit: directed vectors push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_alu_seq_unit;
   import alu_pkg::*;

   localparam int W = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   alu_seq_unit_if #(.W(W)) bus();

   alu_seq_unit #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string        name;
      logic [W-1:0] acc;
      logic [3:0]   flags;
      int           due;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] act;
      logic [31:0] exp;
   } imm_t;

   exp_t exp_q[$];
   imm_t imm_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // monitor: sole owner of the counters
   always @(negedge clk) begin
      exp_t e;
      imm_t m;
      while (imm_q.size() > 0) begin
         m = imm_q.pop_front();
         n_vec++;
         if (m.act !== m.exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", m.name, m.act, m.exp);
         end
      end
      if (rst && bus.done) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_done: acc=%h flags=%b at cycle %0d, no result pending",
                     bus.acc, bus.flags, cyc);
         end else begin
            e = exp_q.pop_front();
            if (bus.acc !== e.acc || bus.flags !== e.flags || cyc != e.due) begin
               n_err++;
               $display("FAIL %s: acc=%h flags=%b cycle=%0d, want acc=%h flags=%b cycle=%0d",
                        e.name, bus.acc, bus.flags, cyc, e.acc, e.flags, e.due);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      imm_q.push_back('{name: name, act: act, exp: exp});
   endtask

   task automatic load(input logic [W-1:0] v);
      @(negedge clk);
      bus.acc_load = 1'b1;
      bus.acc_din  = v;
      @(negedge clk);
      bus.acc_load = 1'b0;
      chk("load", {16'd0, bus.acc}, {16'd0, v});
   endtask

   // mode 0: plain, 1: extra start pulse while busy, 2: acc_load with start
   task automatic do_op(input string name, input logic [5:0] op, input logic [W-1:0] b,
                        input logic [W-1:0] ea, input logic [3:0] ef, input int mode);
      int lat;
      lat = ((op == OP_MUL) || (((op == OP_DIV) || (op == OP_MOD)) && (b != 16'd0))) ? W + 1 : 1;
      @(negedge clk);
      bus.start   = 1'b1;
      bus.opcode  = op;
      bus.operand = b;
      if (mode == 2) begin
         bus.acc_load = 1'b1;
         bus.acc_din  = 16'h0F00;
      end
      exp_q.push_back('{name: name, acc: ea, flags: ef, due: cyc + 1 + lat});
      @(negedge clk);
      bus.start    = 1'b0;
      bus.acc_load = 1'b0;
      chk({name, "_busy"}, {31'd0, bus.busy}, 32'd1);
      if (mode == 1) begin
         bus.start   = 1'b1;
         bus.opcode  = OP_ADD;
         bus.operand = 16'h0001;
         @(negedge clk);
         bus.start = 1'b0;
      end
      for (int i = 0; i < 3 * W && bus.busy; i++) @(negedge clk);
      chk({name, "_idle"}, {31'd0, bus.busy}, 32'd0);
   endtask

   task automatic run(input string name, input logic [W-1:0] init, input logic [5:0] op,
                      input logic [W-1:0] b, input logic [W-1:0] ea, input logic [3:0] ef,
                      input int mode);
      load(init);
      do_op(name, op, b, ea, ef, mode);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.start    = 1'b0;
      bus.opcode   = 6'b000000;
      bus.operand  = 16'h0000;
      bus.acc_load = 1'b0;
      bus.acc_din  = 16'h0000;
      repeat (3) @(negedge clk);
      chk("rst_acc",   {16'd0, bus.acc},   32'd0);
      chk("rst_flags", {28'd0, bus.flags}, 32'd0);
      chk("rst_busy",  {31'd0, bus.busy},  32'd0);
      chk("rst_done",  {31'd0, bus.done},  32'd0);
      rst = 1'b1;

      // reset in the middle of a multiply
      load(16'd3);
      @(negedge clk);
      bus.start   = 1'b1;
      bus.opcode  = OP_MUL;
      bus.operand = 16'd5;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      chk("iter_busy", {31'd0, bus.busy}, 32'd1);
      rst = 1'b0;
      #1;
      chk("abort_acc",   {16'd0, bus.acc},   32'd0);
      chk("abort_flags", {28'd0, bus.flags}, 32'd0);
      chk("abort_busy",  {31'd0, bus.busy},  32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      run("add_ovf", 16'h7FFF, OP_ADD, 16'h0001, 16'h8000, 4'b0101, 0);
      run("cmp_eq",  16'd5,    OP_CMP, 16'd5,    16'd5,    4'b1000, 0);
      do_op("cmp_lt",          OP_CMP, 16'd6,    16'd5,    4'b0110, 0);
      run("mul300",  16'd300,  OP_MUL, 16'd300,  16'h5F90, 4'b0010, 0);
      run("div",     16'd100,  OP_DIV, 16'd7,    16'd14,   4'b0000, 0);
      run("mod",     16'd100,  OP_MOD, 16'd7,    16'd2,    4'b0000, 0);
      do_op("div0",            OP_DIV, 16'd0,    16'hFFFF, 4'b0101, 0);
      run("lsl1",    16'h8001, OP_LSL, 16'd1,    16'h0002, 4'b0010, 0);
      load(16'd2);
      do_op("mul_ign",         OP_MUL, 16'd3,    16'd6,    4'b0000, 1);
      do_op("sub_neg",         OP_SUB, 16'd7,    16'hFFFF, 4'b0110, 0);
      do_op("unknown",         6'b111111, 16'h1234, 16'hFFFF, 4'b0110, 0);
      repeat (4) @(negedge clk);

      run("and",     16'hF0F0, OP_AND, 16'h0FF0, 16'h00F0, 4'b0000, 0);
      run("or",      16'hF0F0, OP_OR,  16'h0F0F, 16'hFFFF, 4'b0100, 0);
      run("xor",     16'hAAAA, OP_XOR, 16'hAAAA, 16'h0000, 4'b1000, 0);
      run("not",     16'h00FF, OP_NOT, 16'h0000, 16'hFF00, 4'b0100, 0);
      run("lsr1",    16'h8001, OP_LSR, 16'd1,    16'h4000, 4'b0010, 0);
      run("lsr0",    16'h1234, OP_LSR, 16'd0,    16'h1234, 4'b0000, 0);
      run("ror4",    16'h8001, OP_ROR, 16'd4,    16'h1800, 4'b0000, 0);
      run("rol4",    16'h8001, OP_ROL, 16'd4,    16'h0018, 4'b0000, 0);
      run("inc_wrap",16'hFFFF, OP_INC, 16'h0000, 16'h0000, 4'b1010, 0);
      run("dec_ovf", 16'h8000, OP_DEC, 16'h0000, 16'h7FFF, 4'b0001, 0);
      run("mov",     16'h1234, OP_MOV, 16'hABCD, 16'hABCD, 4'b0100, 0);
      run("tst",     16'h00F0, OP_TST, 16'h0F00, 16'h00F0, 4'b1000, 0);
      run("sub_brw", 16'h0000, OP_SUB, 16'h0001, 16'hFFFF, 4'b0110, 0);
      run("lsl2",    16'h4000, OP_LSL, 16'd2,    16'h0000, 4'b1010, 0);
      run("add_cy",  16'hFFFF, OP_ADD, 16'h0002, 16'h0001, 4'b0010, 0);
      run("div_big", 16'hFFFF, OP_DIV, 16'h0100, 16'h00FF, 4'b0000, 0);
      run("mul_big", 16'hFFFF, OP_MUL, 16'hFFFF, 16'h0001, 4'b0010, 0);
      run("start_wins", 16'd5, OP_ADD, 16'd1,    16'd6,    4'b0000, 2);

      repeat (5) @(negedge clk);
      chk("pending_results", exp_q.size(), 32'd0);
      for (int i = 0; i < 10 && imm_q.size() > 0; i++) @(negedge clk);
      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Multi-cycle accumulator ALU that sits directly downstream of the CPU control unit.
- Consumes the control unit's one-cycle start pulse, the current opcode and the operand from the selected general-purpose register (X or Y).
- Updates the accumulator and the condition flags used by the branch states.
- Raises busy while working, so the control unit's busy-polling state holds until the result is committed.

Parameters:
- W, 16, datapath and accumulator width in bits; must be a power of two, at least 4.
- SHW, $clog2(W), number of shift-amount bits taken from operand[SHW-1:0].

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle start pulse (Start_ALU_operation); sampled only in IDLE.
- opcode  input  6  ALU opcode, 6'b001100..6'b011101; latched when start is accepted.
- operand  input  W  register X/Y value; latched when start is accepted.
- acc_load  input  1  LDA path write enable (LDA_signal); loads acc from acc_din.
- acc_din  input  W  value from data memory for acc_load.
- acc  output  W  accumulator; drives the ST ACC path.
- flags  output  4  {zero, negative, carry, overflow}, bit 3 down to bit 0.
- busy  output  1  high while an operation is pending (Alu_busy).
- done  output  1  one-cycle pulse in the cycle the result is committed.

Behaviour:
- Reset (rst=0): acc=0, flags=0, busy=0, done=0, FSM state=IDLE. Reset mid-operation aborts the operation with no commit.
- States:
  - IDLE: on start=1, latch opcode/operand, busy<=1 at the same edge. Go to ITER if opcode is MUL/DIV/MOD, otherwise EXEC.
  - EXEC: compute and commit; done<=1, busy<=0; go to IDLE.
  - ITER: one shift-add (MUL) or restoring-subtract (DIV/MOD) step per cycle, W cycles; then go to COMMIT.
  - COMMIT: write the result; done<=1, busy<=0; go to IDLE.
- Latency (edge N samples start):
  - single-cycle ops: busy high at N, done at N+1, busy low at N+1.
  - MUL/DIV/MOD: done at N+W+1.
- busy is registered and is already 1 in the cycle after start, matching the control unit's START_ALU -> CHECK_BUSY_ALU sequence.
- Opcodes (B = latched operand):
  - 001100 ADD: acc+B
  - 001101 SUB: acc-B
  - 001110 AND
  - 001111 OR
  - 010000 XOR
  - 010001 NOT: ~acc
  - 010010 LSL: acc<<B[SHW-1:0]
  - 010011 LSR: acc>>B[SHW-1:0]
  - 010100 ROR
  - 010101 ROL
  - 010110 MUL
  - 010111 DIV
  - 011000 MOD
  - 011001 INC: acc+1
  - 011010 DEC: acc-1
  - 011011 CMP: acc-B, flags only
  - 011100 TST: acc&B, flags only
  - 011101 MOV: acc=B
- Flags, written only at commit:
  - zero = (result==0); negative = result[W-1].
  - ADD/INC: carry = carry-out of bit W-1; overflow = two's-complement signed overflow.
  - SUB/DEC/CMP: carry = borrow, i.e. acc<B unsigned; overflow = signed overflow.
  - LSL/LSR: carry = last bit shifted out, 0 if amount=0; overflow=0.
  - ROR/ROL/logic/MOV/TST: carry=0, overflow=0.
  - MUL: acc = low W bits of the 2W-bit product; carry = |high W bits; overflow=0.
  - DIV/MOD: unsigned quotient/remainder; carry=0, overflow=0.
- Divide by zero (DIV/MOD with B=0): skips ITER. Goes EXEC-like to COMMIT at N+1 with acc=all ones, overflow=1, zero=0, negative=1, carry=0.
- Unknown opcode with start: busy for one cycle, done pulses, acc and flags unchanged.
- start while busy: ignored, no queueing.
- acc_load: accepted only in IDLE, and only when start=0. acc<=acc_din; flags unchanged. If start=1 and acc_load=1 in the same cycle, start wins and acc_load is dropped.
- Arithmetic wraps modulo 2^W.

Decomposition:
- Shared package alu_pkg: the 18 opcode localparams, flag bit indices (FLG_Z=3, FLG_N=2, FLG_C=1, FLG_V=0), FSM state encodings.
- Sub-module alu_muldiv_core: iterative W-step multiplier/restoring divider with start/step/done. The top holds the FSM, single-cycle datapath, acc and flags.

Test Plan:
- Reset during an ITER cycle of MUL -> acc=0, flags=0, busy=0 immediately; next start runs normally.
- acc_load 16'h7FFF, start ADD B=1 -> busy high the cycle after start, done at N+1; acc=16'h8000, flags=4'b0101 (N, V).
- acc=5, CMP B=5 -> flags=4'b1000, acc stays 5; then CMP B=6 -> flags=4'b0110 (N, C).
- acc=300, MUL B=300 -> busy high for W+1=17 cycles; acc=16'h5F90, carry=1 (product 90000).
- acc=100, DIV B=7 -> acc=14; then acc=100, MOD B=7 -> acc=2; then DIV B=0 -> done at N+1, acc=16'hFFFF, flags=4'b0101.
- acc=16'h8001, LSL B=1 -> acc=16'h0002, carry=1. Then a second start pulse during a MUL is ignored (only one done pulse). Then opcode 6'b111111 -> done at N+1, acc and flags unchanged.
